// File: rtl/restoring_div4_pkg.sv
// Shared definitions for the restoring divider.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   WIDTH_DEF : default operand width
//   CNT_W     : iteration counter width for the default operand width
//   cnt_width : counter width for an arbitrary operand width (at least 1 bit)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    // The counter only has to reach WIDTH-1, which always fits in clog2(WIDTH) bits.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/restoring_div4_if.sv
// Start/done handshake bundle of the restoring divider.
//   start        : request, accepted only while busy is low
//   dividend     : unsigned dividend, sampled on accept
//   divisor      : unsigned divisor, sampled on accept
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid
//   quotient     : result, held until the next done
//   remainder    : result, held until the next done
//   div_by_zero  : divisor was zero on the last accept
// The master modport belongs to the requester; the slave modport to the divider.
interface restoring_div4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_div4_sub.sv
// Combinational ripple-borrow subtractor: diff = a - b, bout = 1 when a < b.
//   a, b  : N-bit unsigned operands
//   diff  : N-bit difference (modulo 2^N)
//   bout  : borrow out of the most significant bit
module borrow_sub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);
    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        // Borrow when b exceeds a at this bit, or they are equal and a borrow arrives.
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[N];
endmodule

// File: rtl/restoring_div4.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit per clock: {R,Q} shifts left, the borrow subtractor forms
// R - divisor, and the difference is kept (Q bit 1) or discarded (Q bit 0).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   bus    : restoring_div4_if.slave (start, dividend, divisor, busy, done,
//            quotient, remainder, div_by_zero)
// Optional build macro DIV_ZERO_DETECT_EN: a zero divisor skips the iterations
// and completes one cycle after accept with div_by_zero set. Without it the
// normal iterations run (giving all-ones quotient and remainder=dividend) and
// div_by_zero is tied low.
module restoring_div4
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    restoring_div4_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam int RW = WIDTH + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;       // partial remainder; always < divisor, so WIDTH bits suffice
    logic [WIDTH-1:0] q_q, q_d;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
    logic             zflag_q, zflag_d;  // current operation has a zero divisor
`endif

    logic [RW-1:0]    r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [RW-1:0]    trial_diff;
    logic             trial_bout;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_iter;
    logic             unused_diff_msb;

    // Shifted remainder carries one extra bit so the trial subtract cannot overflow.
    assign r_shift = {r_q, q_q[WIDTH-1]};
    assign q_shift = {q_q[WIDTH-2:0], 1'b0};

    borrow_sub_stage #(
        .N (RW)
    ) u_sub (
        .a    (r_shift),
        .b    ({1'b0, dvs_q}),
        .diff (trial_diff),
        .bout (trial_bout)
    );

    // A kept difference is below the divisor, so its top bit is always zero.
    assign unused_diff_msb = trial_diff[RW-1];
    assign r_next    = trial_bout ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign q_next    = {q_shift[WIDTH-1:1], ~trial_bout};

    assign accept    = bus.start && (state_q != RUN);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = dbz_q;
        zflag_d = zflag_q;
`endif

        case (state_q)
            RUN: begin
`ifdef DIV_ZERO_DETECT_EN
                if (zflag_q) begin
                    // q_q still holds the untouched dividend here.
                    state_d = DONE;
                    quot_d  = '1;
                    rem_d   = q_q;
                end else
`endif
                begin
                    r_d = r_next;
                    q_d = q_next;
                    if (last_iter) begin
                        state_d = DONE;
                        quot_d  = q_next;
                        rem_d   = r_next;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // Accept wins over DONE -> IDLE so back-to-back requests lose no cycle.
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = bus.dividend;
            dvs_d   = bus.divisor;
`ifdef DIV_ZERO_DETECT_EN
            dbz_d   = (bus.divisor == '0);
            zflag_d = (bus.divisor == '0);
`endif
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
            zflag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
            zflag_q <= zflag_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule
